// File: rtl/arith_pkg.sv
// Shared encodings for the chunked add/subtract engine: operation modes,
// FSM states and small mode-decoding helpers.
package arith_pkg;

    localparam logic [1:0] MODE_ADD  = 2'b00;
    localparam logic [1:0] MODE_SUB  = 2'b01;
    localparam logic [1:0] MODE_B2A  = 2'b10;
    localparam logic [1:0] MODE_RSUB = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_PASS1 = 2'b01,
        ST_PASS2 = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    // Every mode except plain addition is X + ~Y + 1.
    function automatic logic mode_is_sub(input logic [1:0] m);
        return (m != MODE_ADD);
    endfunction

    // Modes whose first pass takes B as the minuend.
    function automatic logic mode_swaps(input logic [1:0] m);
        return (m == MODE_B2A) || (m == MODE_RSUB);
    endfunction

endpackage

// File: rtl/adder_chunk.sv
// Combinational W-bit ripple adder built from full_adder cells; also exposes
// the carry into the MSB so the caller can form signed overflow.
module adder_chunk #(
    parameter int W = 4
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout,
    output logic         cmsb
);

    logic [W:0] w_c;

    assign w_c[0] = cin;

    for (genvar i = 0; i < W; i++) begin : g_fa
        full_adder u_fa (
            .a    (x[i]),
            .b    (y[i]),
            .cin  (w_c[i]),
            .s    (s[i]),
            .cout (w_c[i+1])
        );
    end

    assign cout = w_c[W];
    assign cmsb = w_c[W-1];

endmodule

// File: rtl/full_adder.sv
// One-bit full adder, the leaf cell of the chunk ripple adder.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/seq_addsub_chunked.sv
// Multi-cycle add/subtract engine: one CHUNK-bit slice per clock, carry held
// in a register between slices; mode 10 chains a second subtraction pass.
module seq_addsub_chunked
    import arith_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);

    localparam int K     = WIDTH / CHUNK;
    localparam int CNT_W = (K > 1) ? $clog2(K) : 1;

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_x;
    logic [WIDTH-1:0]   r_y;
    logic [WIDTH-1:0]   r_acc;
    logic [1:0]         r_mode;
    logic               r_carry;
    logic               r_ovf1;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_result;
    logic               r_cout;
    logic               r_ovf;

    logic [CHUNK-1:0]   w_x_chunk;
    logic [CHUNK-1:0]   w_y_chunk;
    logic [CHUNK-1:0]   w_s;
    logic               w_cout;
    logic               w_cmsb;
    logic               w_last;
    logic               w_accept;
    logic               w_busy;
    logic               w_done;
    logic               w_pass_ovf;
    logic [WIDTH-1:0]   w_pass_res;

    assign w_x_chunk  = r_x[int'(r_cnt) * CHUNK +: CHUNK];
    assign w_y_chunk  = mode_is_sub(r_mode) ? ~r_y[int'(r_cnt) * CHUNK +: CHUNK]
                                            :  r_y[int'(r_cnt) * CHUNK +: CHUNK];
    assign w_last     = (r_cnt == CNT_W'(K - 1));
    assign w_accept   = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_pass_ovf = w_cmsb ^ w_cout;

    adder_chunk #(.W(CHUNK)) u_adder (
        .x    (w_x_chunk),
        .y    (w_y_chunk),
        .cin  (r_carry),
        .s    (w_s),
        .cout (w_cout),
        .cmsb (w_cmsb)
    );

    // Full pass value: earlier slices from the accumulator, top slice live.
    always_comb begin
        w_pass_res = r_acc;
        w_pass_res[WIDTH-1 -: CHUNK] = w_s;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  w_state_next = start ? ST_PASS1 : ST_IDLE;
            ST_PASS1: begin
                if (w_last) begin
                    w_state_next = (r_mode == MODE_B2A) ? ST_PASS2 : ST_DONE;
                end else begin
                    w_state_next = ST_PASS1;
                end
            end
            ST_PASS2: w_state_next = w_last ? ST_DONE : ST_PASS2;
            ST_DONE:  w_state_next = start ? ST_PASS1 : ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // Status decode from the state register.
    always_comb begin
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            ST_PASS1, ST_PASS2: w_busy = 1'b1;
            ST_DONE:            w_done = 1'b1;
            default: begin
                w_busy = 1'b0;
                w_done = 1'b0;
            end
        endcase
    end

    // Operand capture, per-slice accumulation and end-of-pass bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_x      <= '0;
            r_y      <= '0;
            r_acc    <= '0;
            r_mode   <= MODE_ADD;
            r_carry  <= 1'b0;
            r_ovf1   <= 1'b0;
            r_cnt    <= '0;
            r_result <= '0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
        end else if (w_accept) begin
            r_x     <= mode_swaps(mode) ? b : a;
            r_y     <= mode_swaps(mode) ? a : b;
            r_acc   <= '0;
            r_mode  <= mode;
            r_carry <= mode_is_sub(mode);
            r_ovf1  <= 1'b0;
            r_cnt   <= '0;
        end else if (w_busy) begin
            if (!w_last) begin
                r_acc[int'(r_cnt) * CHUNK +: CHUNK] <= w_s;
                r_carry <= w_cout;
                r_cnt   <= r_cnt + CNT_W'(1);
            end else if ((r_state == ST_PASS1) && (r_mode == MODE_B2A)) begin
                // Second pass subtracts A again from the first-pass difference.
                r_x     <= w_pass_res;
                r_carry <= 1'b1;
                r_ovf1  <= w_pass_ovf;
                r_cnt   <= '0;
            end else begin
                r_result <= w_pass_res;
                r_cout   <= w_cout;
                r_ovf    <= w_pass_ovf | r_ovf1;
                r_carry  <= 1'b0;
                r_cnt    <= '0;
            end
        end
    end

    assign busy   = w_busy;
    assign done   = w_done;
    assign result = r_result;
    assign cout   = r_cout;
    assign ovf    = r_ovf;

endmodule

// File: tb/tb_seq_addsub_chunked.sv
// Randomised self-checking bench for seq_addsub_chunked (16/4 and 8/8 builds)
// against an arithmetic reference model.
module tb_seq_addsub_chunked;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        st16 = 1'b0;
    logic        st8 = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [15:0] a = 16'h0;
    logic [15:0] b = 16'h0;

    logic        d16_busy, d16_done, d16_cout, d16_ovf;
    logic [15:0] d16_result;
    logic        d8_busy, d8_done, d8_cout, d8_ovf;
    logic [7:0]  d8_result;

    int n_vec = 0;
    int n_err = 0;
    bit cur_sel = 1'b0;

    always #5 clk = ~clk;

    seq_addsub_chunked #(.WIDTH(16), .CHUNK(4)) dut16 (
        .clk(clk), .rst(rst), .start(st16), .mode(mode), .a(a), .b(b),
        .busy(d16_busy), .done(d16_done), .result(d16_result),
        .cout(d16_cout), .ovf(d16_ovf)
    );

    seq_addsub_chunked #(.WIDTH(8), .CHUNK(8)) dut8 (
        .clk(clk), .rst(rst), .start(st8), .mode(mode), .a(a[7:0]), .b(b[7:0]),
        .busy(d8_busy), .done(d8_done), .result(d8_result),
        .cout(d8_cout), .ovf(d8_ovf)
    );

    wire        o_busy   = cur_sel ? d8_busy : d16_busy;
    wire        o_done   = cur_sel ? d8_done : d16_done;
    wire        o_cout   = cur_sel ? d8_cout : d16_cout;
    wire        o_ovf    = cur_sel ? d8_ovf  : d16_ovf;
    wire [15:0] o_result = cur_sel ? {8'h00, d8_result} : d16_result;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain modular arithmetic on w-bit values.
    task automatic model(input int w, input logic [1:0] m, input logic [31:0] av,
                         input logic [31:0] bv, output logic [31:0] r,
                         output logic c, output logic v);
        logic [31:0] mask, msb, x, y, p, s;
        mask = (32'd1 << w) - 32'd1;
        msb  = 32'd1 << (w - 1);
        x = av & mask;
        y = bv & mask;
        case (m)
            2'b00: begin
                s = x + y;
                r = s & mask;
                c = ((s >> w) & 32'd1) != 32'd0;
                v = ((~(x ^ y)) & (x ^ r) & msb) != 32'd0;
            end
            2'b01: begin
                r = (x - y) & mask;
                c = (x >= y);
                v = ((x ^ y) & (x ^ r) & msb) != 32'd0;
            end
            2'b11: begin
                r = (y - x) & mask;
                c = (y >= x);
                v = ((y ^ x) & (y ^ r) & msb) != 32'd0;
            end
            default: begin
                p = (y - x) & mask;
                v = ((y ^ x) & (y ^ p) & msb) != 32'd0;
                r = (p - x) & mask;
                c = (p >= x);
                v = v | (((p ^ x) & (p ^ r) & msb) != 32'd0);
            end
        endcase
    endtask

    task automatic run_op(input bit sel, input logic [1:0] m, input logic [15:0] av,
                          input logic [15:0] bv, input int gap, input bit inject);
        int w, k, exp_lat, lat, busy_gap, overlap;
        logic [31:0] er;
        logic ec, ev;
        w = sel ? 8 : 16;
        k = sel ? 1 : 4;
        exp_lat = (m == 2'b10) ? 2 * k : k;
        model(w, m, {16'h0, av}, {16'h0, bv}, er, ec, ev);
        for (int i = 0; i < gap; i++) begin
            @(posedge clk); #1;
            if (i == 0) check_eq("done_single_pulse", {31'b0, o_done}, 32'd0);
        end
        @(negedge clk);
        cur_sel = sel;
        mode = m; a = av; b = bv;
        if (sel) st8 = 1'b1; else st16 = 1'b1;
        @(posedge clk); #1;
        st8 = 1'b0; st16 = 1'b0;
        lat = 0; busy_gap = 0; overlap = 0;
        while (lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (o_done && o_busy) overlap++;
            if (o_done) break;
            if (!o_busy) busy_gap++;
            if (inject && lat == 1) begin
                a = ~av; b = av ^ bv ^ 16'h5A5A;
                if (sel) st8 = 1'b1; else st16 = 1'b1;
            end else if (inject && lat == 2) begin
                st8 = 1'b0; st16 = 1'b0;
            end
        end
        st8 = 1'b0; st16 = 1'b0;
        check_eq("done_seen", {31'b0, o_done}, 32'd1);
        check_eq("latency", lat, exp_lat);
        check_eq("busy_during_op", busy_gap, 0);
        check_eq("busy_done_overlap", overlap, 0);
        check_eq("result", {16'h0, o_result}, er);
        check_eq("cout", {31'b0, o_cout}, {31'b0, ec});
        check_eq("ovf", {31'b0, o_ovf}, {31'b0, ev});
    endtask

    initial begin
        int nd;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_busy", {31'b0, d16_busy}, 32'd0);
        check_eq("rst_done", {31'b0, d16_done}, 32'd0);
        check_eq("rst_result", {16'h0, d16_result}, 32'd0);
        check_eq("rst_cout_ovf", {30'b0, d16_cout, d16_ovf}, 32'd0);
        check_eq("rst_result8", {24'h0, d8_result}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed cases from the requirements.
        run_op(1'b0, 2'b00, 16'h00FF, 16'h0001, 1, 1'b0);
        check_eq("add_0100", {16'h0, d16_result}, 32'h0100);
        run_op(1'b0, 2'b01, 16'h0000, 16'h0001, 1, 1'b0);
        check_eq("sub_ffff", {16'h0, d16_result}, 32'hFFFF);
        run_op(1'b0, 2'b01, 16'h8000, 16'h0001, 0, 1'b0);
        check_eq("sub_ovf", {15'h0, d16_ovf, d16_result}, 32'h17FFF);
        run_op(1'b0, 2'b10, 16'h0003, 16'h000A, 2, 1'b0);
        check_eq("b2a_0004", {16'h0, d16_result}, 32'h0004);
        run_op(1'b0, 2'b10, 16'h5000, 16'h0000, 0, 1'b0);
        check_eq("b2a_ovf", {15'h0, d16_ovf, d16_result}, 32'h16000);
        run_op(1'b0, 2'b00, 16'h1234, 16'h1111, 1, 1'b1);
        check_eq("ignored_start", {16'h0, d16_result}, 32'h2345);
        run_op(1'b1, 2'b00, 16'h00FF, 16'h0001, 1, 1'b0);
        check_eq("k1_wrap", {23'h0, d8_cout, d8_result}, 32'h100);
        run_op(1'b1, 2'b11, 16'h0005, 16'h0003, 0, 1'b0);

        // Reset during cycle 2 of a two-pass operation.
        @(negedge clk);
        cur_sel = 1'b0;
        mode = 2'b10; a = 16'h0003; b = 16'h000A; st16 = 1'b1;
        @(posedge clk); #1;
        st16 = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        rst = 1'b1; st16 = 1'b1;
        @(posedge clk); #1;
        check_eq("mid_rst_busy", {31'b0, d16_busy}, 32'd0);
        check_eq("mid_rst_done", {31'b0, d16_done}, 32'd0);
        check_eq("mid_rst_result", {16'h0, d16_result}, 32'd0);
        check_eq("mid_rst_flags", {30'b0, d16_cout, d16_ovf}, 32'd0);
        @(negedge clk);
        rst = 1'b0; st16 = 1'b0;
        nd = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (d16_done || d16_busy) nd++;
        end
        check_eq("no_done_after_abort", nd, 0);
        run_op(1'b0, 2'b00, 16'h0001, 16'h0001, 0, 1'b0);
        check_eq("post_rst_add", {16'h0, d16_result}, 32'h0002);

        // Randomised operations on both builds.
        for (int i = 0; i < 40; i++) begin
            run_op(1'b0, 2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom),
                   int'($urandom_range(0, 2)), ($urandom_range(0, 4) == 0));
        end
        for (int i = 0; i < 20; i++) begin
            run_op(1'b1, 2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom),
                   int'($urandom_range(0, 2)), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
